// File: rtl/vga_pkg.sv
// ============================================================================
// Module  : vga_pkg
// Purpose : Shared constants and types for the VGA/HDMI timing path.
//           RGB565 colour constants, a timing-set struct, and the CEA
//           1080p60 and 720p60 timing sets.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  // RGB565 colour constants
  localparam logic [15:0] c_RGB565_BLACK = 16'h0000;
  localparam logic [15:0] c_RGB565_WHITE = 16'hFFFF;
  localparam logic [15:0] c_RGB565_RED   = 16'hF800;
  localparam logic [15:0] c_RGB565_GREEN = 16'h07E0;
  localparam logic [15:0] c_RGB565_BLUE  = 16'h001F;

  // One complete horizontal + vertical timing set
  typedef struct packed {
    logic [11:0] h_sync;
    logic [11:0] h_back;
    logic [11:0] h_valid;
    logic [11:0] h_front;
    logic [11:0] v_sync;
    logic [11:0] v_back;
    logic [11:0] v_valid;
    logic [11:0] v_front;
  } vga_timing_t;

  // CEA 1080p60: 148.5 MHz, 2200 x 1125 total
  localparam vga_timing_t c_TIMING_1080P60 = '{
    h_sync: 12'd44, h_back: 12'd148, h_valid: 12'd1920, h_front: 12'd88,
    v_sync: 12'd5,  v_back: 12'd36,  v_valid: 12'd1080, v_front: 12'd4
  };

  // CEA 720p60: 74.25 MHz, 1650 x 750 total
  localparam vga_timing_t c_TIMING_720P60 = '{
    h_sync: 12'd40, h_back: 12'd220, h_valid: 12'd1280, h_front: 12'd110,
    v_sync: 12'd5,  v_back: 12'd20,  v_valid: 12'd720,  v_front: 12'd5
  };

endpackage

`default_nettype wire

// File: rtl/vga_delay_line.sv
// ============================================================================
// Module  : vga_delay_line
// Purpose : DEPTH x WIDTH shift register with synchronous reset value.
//           Used to align sync/enable flags with returned pixel data.
// Ports   : clk  - clock
//           rst  - synchronous active-high reset (loads RST_VAL everywhere)
//           i_d  - input word
//           o_q  - input word delayed by DEPTH clocks
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_delay_line #(
  parameter int               DEPTH   = 1,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= RST_VAL;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module  : vga_timing_gen
// Purpose : Display timing master. Runs line/frame counters, issues pixel
//           coordinate requests to a picture source, and re-aligns the
//           returned RGB565 data with delayed hsync/vsync/de so that every
//           output is PIX_LAT+2 clocks behind the counters.
// Macro   : VGA_TIMING_STATUS_EN - enables sof_o pulse and frame_cnt_o.
//           When undefined both outputs are tied to 0.
// Ports   : sys_clk_i   - pixel clock
//           rst_i       - synchronous active-high reset
//           pix_req_o   - pixel request (coordinates valid)
//           pix_x_o/y_o - active-area coordinates, 0 when no request
//           pix_data_i  - RGB565 returned PIX_LAT clocks after request
//           hsync_o, vsync_o, de_o, rgb_o - aligned display outputs
//           frame_cnt_o - frame counter (status build)
//           sof_o       - start-of-frame pulse (status build)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_SYNC   = int'(c_TIMING_1080P60.h_sync),
  parameter int H_BACK   = int'(c_TIMING_1080P60.h_back),
  parameter int H_VALID  = int'(c_TIMING_1080P60.h_valid),
  parameter int H_FRONT  = int'(c_TIMING_1080P60.h_front),
  parameter int V_SYNC   = int'(c_TIMING_1080P60.v_sync),
  parameter int V_BACK   = int'(c_TIMING_1080P60.v_back),
  parameter int V_VALID  = int'(c_TIMING_1080P60.v_valid),
  parameter int V_FRONT  = int'(c_TIMING_1080P60.v_front),
  parameter bit SYNC_POL = 1'b1,
  parameter int PIX_LAT  = 1
) (
  input  logic        sys_clk_i,
  input  logic        rst_i,
  output logic        pix_req_o,
  output logic [11:0] pix_x_o,
  output logic [11:0] pix_y_o,
  input  logic [15:0] pix_data_i,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic [15:0] rgb_o,
  output logic [15:0] frame_cnt_o,
  output logic        sof_o
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

  localparam logic [11:0] c_H_LAST      = 12'(H_TOTAL - 1);
  localparam logic [11:0] c_V_LAST      = 12'(V_TOTAL - 1);
  localparam logic [11:0] c_H_SYNC_END  = 12'(H_SYNC);
  localparam logic [11:0] c_V_SYNC_END  = 12'(V_SYNC);
  localparam logic [11:0] c_H_ACT_START = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] c_V_ACT_START = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] c_H_ACT_END   = 12'(H_SYNC + H_BACK + H_VALID);
  localparam logic [11:0] c_V_ACT_END   = 12'(V_SYNC + V_BACK + V_VALID);

  if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_bad_total
    $error("vga_timing_gen: H or V total exceeds 12-bit counter range");
  end
  if (PIX_LAT < 1 || PIX_LAT > 4) begin : g_bad_lat
    $error("vga_timing_gen: PIX_LAT must be in 1..4");
  end

  // --------------------------------------------------------------------------
  // Line / frame counters
  // --------------------------------------------------------------------------
  logic [11:0] r_h_cnt;
  logic [11:0] r_v_cnt;

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == c_H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == c_V_LAST) ? 12'd0 : r_v_cnt + 12'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 12'd1;
    end
  end

  // Region decode on the live counters
  logic w_hs_raw, w_vs_raw, w_h_act, w_v_act, w_req;

  assign w_hs_raw = (r_h_cnt < c_H_SYNC_END);
  assign w_vs_raw = (r_v_cnt < c_V_SYNC_END);
  assign w_h_act  = (r_h_cnt >= c_H_ACT_START) && (r_h_cnt < c_H_ACT_END);
  assign w_v_act  = (r_v_cnt >= c_V_ACT_START) && (r_v_cnt < c_V_ACT_END);
  assign w_req    = w_h_act && w_v_act;

  // --------------------------------------------------------------------------
  // Request stage: coordinates to the source, raw syncs carried alongside
  // --------------------------------------------------------------------------
  logic        r_pix_req, r_hs_req, r_vs_req;
  logic [11:0] r_pix_x, r_pix_y;

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      r_pix_req <= 1'b0;
      r_hs_req  <= 1'b0;
      r_vs_req  <= 1'b0;
      r_pix_x   <= '0;
      r_pix_y   <= '0;
    end else begin
      r_pix_req <= w_req;
      r_hs_req  <= w_hs_raw;
      r_vs_req  <= w_vs_raw;
      r_pix_x   <= w_req ? (r_h_cnt - c_H_ACT_START) : 12'd0;
      r_pix_y   <= w_req ? (r_v_cnt - c_V_ACT_START) : 12'd0;
    end
  end

  assign pix_req_o = r_pix_req;
  assign pix_x_o   = r_pix_x;
  assign pix_y_o   = r_pix_y;

  // --------------------------------------------------------------------------
  // Alignment: flags wait PIX_LAT clocks in the delay line so the request
  // flag lines up with pix_data_i; the output register adds the final clock.
  // Bit map: [0] request, [1] vs, [2] hs, [3] sof (status build only).
  // --------------------------------------------------------------------------
`ifdef VGA_TIMING_STATUS_EN
  localparam int c_DL_W = 4;
  logic r_sof_req;

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) r_sof_req <= 1'b0;
    else       r_sof_req <= (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
  end

  logic [c_DL_W-1:0] w_dl_in;
  assign w_dl_in = {r_sof_req, r_hs_req, r_vs_req, r_pix_req};
`else
  localparam int c_DL_W = 3;
  logic [c_DL_W-1:0] w_dl_in;
  assign w_dl_in = {r_hs_req, r_vs_req, r_pix_req};
`endif

  logic [c_DL_W-1:0] w_dl_out;

  vga_delay_line #(
    .DEPTH   (PIX_LAT),
    .WIDTH   (c_DL_W),
    .RST_VAL ('0)
  ) u_align (
    .clk (sys_clk_i),
    .rst (rst_i),
    .i_d (w_dl_in),
    .o_q (w_dl_out)
  );

  // Output stage
  logic        r_hsync, r_vsync, r_de;
  logic [15:0] r_rgb;

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_de    <= 1'b0;
      r_rgb   <= c_RGB565_BLACK;
    end else begin
      r_hsync <= w_dl_out[2] ^ ~SYNC_POL;
      r_vsync <= w_dl_out[1] ^ ~SYNC_POL;
      r_de    <= w_dl_out[0];
      // Blank outside requested pixels so stray source data never leaks out
      r_rgb   <= w_dl_out[0] ? pix_data_i : c_RGB565_BLACK;
    end
  end

  assign hsync_o = r_hsync;
  assign vsync_o = r_vsync;
  assign de_o    = r_de;
  assign rgb_o   = r_rgb;

  // --------------------------------------------------------------------------
  // Status: start-of-frame pulse and frame counter
  // --------------------------------------------------------------------------
`ifdef VGA_TIMING_STATUS_EN
  logic        r_sof;
  logic [15:0] r_frame_cnt;

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      r_sof       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_sof <= w_dl_out[3];
      if (r_sof) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign sof_o       = r_sof;
  assign frame_cnt_o = r_frame_cnt;
`else
  assign sof_o       = 1'b0;
  assign frame_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module  : tb_vga_timing_gen
// Purpose : Self-checking bench for vga_timing_gen with reduced timing
//           (H 4/4/8/4, V 2/2/4/2). Two instances: PIX_LAT=1 active-high
//           sync and PIX_LAT=3 active-low sync. A coordinate loopback source
//           returns {y[3:0],x}; random data is returned on idle clocks.
//           Directed and random mid-frame resets are applied.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

  localparam int HS = 4, HB = 4, HV = 8, HF = 4;
  localparam int VS = 2, VB = 2, VV = 4, VF = 2;
  localparam int HT = HS + HB + HV + HF;   // 20
  localparam int VT = VS + VB + VV + VF;   // 10
  localparam int FT = HT * VT;             // 200

  typedef struct {
    int          pos;
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic [15:0] rgb;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: what the display must show for frame position pos,
  // computed straight from the segment layout of a line and a frame.
  function automatic exp_t model(input int pos);
    exp_t e;
    int h, v;
    h     = pos % HT;
    v     = (pos / HT) % VT;
    e.pos = pos;
    e.hs  = (h < HS);
    e.vs  = (v < VS);
    e.de  = (h >= HS + HB) && (h < HS + HB + HV) && (v >= VS + VB) && (v < VS + VB + VV);
    e.x   = e.de ? 12'(h - (HS + HB)) : 12'd0;
    e.y   = e.de ? 12'(v - (VS + VB)) : 12'd0;
    e.rgb = e.de ? {e.y[3:0], e.x} : 16'h0000;
    return e;
  endfunction

  function automatic exp_t idle();
    exp_t e;
    e.pos = -1; e.hs = 1'b0; e.vs = 1'b0; e.de = 1'b0;
    e.x = '0; e.y = '0; e.rgb = '0;
    return e;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int L   = (gi == 0) ? 1 : 3;
    localparam bit POL = (gi == 0);

    logic        rst = 1'b1;
    logic        req, hs, vs, de, sof;
    logic [11:0] x, y;
    logic [15:0] pdata = 16'hA5A5;
    logic [15:0] rgb, fcnt;
    logic [24:0] src_q[$];
    exp_t        req_q[$];
    exp_t        out_q[$];
    bit          last_rst = 1'b1;
    bit          done = 1'b0;

    vga_timing_gen #(
      .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
      .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF),
      .SYNC_POL(POL), .PIX_LAT(L)
    ) u_dut (
      .sys_clk_i  (clk),
      .rst_i      (rst),
      .pix_req_o  (req),
      .pix_x_o    (x),
      .pix_y_o    (y),
      .pix_data_i (pdata),
      .hsync_o    (hs),
      .vsync_o    (vs),
      .de_o       (de),
      .rgb_o      (rgb),
      .frame_cnt_o(fcnt),
      .sof_o      (sof)
    );

    // Pixel source: answers each request exactly L clocks later
    initial begin
      logic [24:0] s;
      forever begin
        @(negedge clk);
        src_q.push_back({req, y, x});
        if (src_q.size() > L) begin
          s = src_q.pop_front();
          pdata = s[24] ? {s[15:12], s[11:0]} : 16'($urandom);
        end else begin
          pdata = 16'($urandom);
        end
      end
    end

    // Stimulus: reset, two frames, directed reset at h=10 v=3, random resets
    initial begin
      rst = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (2 * FT + 3 * HT + 10) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        @(negedge clk);
        if ($urandom_range(0, 799) == 0) begin
          rst = 1'b1;
          repeat ($urandom_range(1, 3)) @(negedge clk);
          rst = 1'b0;
        end
      end
      repeat (2 * FT) @(negedge clk);
      done = 1'b1;
    end

    // Model: one expected entry per frame position since reset release
    initial begin
      int k;
      k = 0;
      forever begin
        @(posedge clk);
        last_rst = rst;
        if (rst) begin
          k = 0;
          req_q.delete();
          out_q.delete();
        end else begin
          req_q.push_back(model(k));
          out_q.push_back(model(k));
          k++;
        end
      end
    end

    // Monitor / scoreboard
    initial begin
      exp_t e;
      int   de_cnt, hs_cnt, vs_cnt, exp_fc;
      logic e_sof;
      logic [15:0] e_fc;
      de_cnt = 0; hs_cnt = 0; vs_cnt = 0; exp_fc = 0;
      forever begin
        @(negedge clk);
        if (last_rst) begin
          de_cnt = 0; hs_cnt = 0; vs_cnt = 0; exp_fc = 0;
        end

        e = (req_q.size() > 0) ? req_q.pop_front() : idle();
        check($sformatf("req[%0d]", gi), {39'd0, req, x, y}, {39'd0, e.de, e.x, e.y});

        e = (out_q.size() > L + 1) ? out_q.pop_front() : idle();
`ifdef VGA_TIMING_STATUS_EN
        e_sof = (e.pos >= 0) && (e.pos % FT == 0);
        e_fc  = 16'(exp_fc);
`else
        e_sof = 1'b0;
        e_fc  = 16'h0000;
`endif
        check($sformatf("out[%0d] pos=%0d {sof,fcnt,hs,vs,de,rgb}", gi, e.pos),
              {29'd0, sof, fcnt, hs, vs, de, rgb},
              {29'd0, e_sof, e_fc, (e.hs ? POL : !POL), (e.vs ? POL : !POL), e.de, e.rgb});
        if (e_sof) exp_fc++;

        if (e.pos >= 0) begin
          de_cnt += int'(de);
          hs_cnt += int'(hs == POL);
          vs_cnt += int'(vs == POL);
          if (e.pos % FT == FT - 1) begin
            check($sformatf("frame[%0d] de/hs/vs clocks", gi),
                  {16'd0, 16'(de_cnt), 16'(hs_cnt), 16'(vs_cnt)},
                  {16'd0, 16'(HV * VV), 16'(HS * VT), 16'(VS * HT)});
            de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
          end
        end
      end
    end
  end

  initial begin
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk);
      if (g_inst[0].done && g_inst[1].done) break;
    end
    if (!(g_inst[0].done && g_inst[1].done)) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: done=%b%b expected 11", g_inst[1].done, g_inst[0].done);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Display-side timing master for the HDMI/VGA path. Generates the line and frame counters, the hsync, vsync and data-enable signals, and per-pixel coordinates for a pattern/picture source.
- Receives RGB565 pixel data back from that source after a fixed latency. Re-aligns the data with the delayed sync and enable signals and drives the encoder/PHY.
- Default timing is CEA 1080p60: 148.5 MHz, H total 2200, V total 1125.

Parameters:
- H_SYNC, 44, hsync width in clocks
- H_BACK, 148, horizontal back porch
- H_VALID, 1920, active pixels per line
- H_FRONT, 88, horizontal front porch
- V_SYNC, 5, vsync width in lines
- V_BACK, 36, vertical back porch
- V_VALID, 1080, active lines per frame
- V_FRONT, 4, vertical front porch
- SYNC_POL, 1, 1 = active-high sync, 0 = active-low sync
- PIX_LAT, 1, clocks from pix_req_o/pix_x_o to a valid pix_data_i (1..4)

Ports:
- sys_clk_i  in  1  pixel clock
- rst_i  in  1  synchronous active-high reset
- pix_req_o  out  1  coordinate valid; pixel requested
- pix_x_o  out  12  active-area x coordinate (0..H_VALID-1)
- pix_y_o  out  12  active-area y coordinate (0..V_VALID-1)
- pix_data_i  in  16  RGB565 pixel returned PIX_LAT clocks after the request
- hsync_o  out  1  horizontal sync
- vsync_o  out  1  vertical sync
- de_o  out  1  data enable
- rgb_o  out  16  RGB565 output pixel
- frame_cnt_o  out  16  frame counter (optional feature)
- sof_o  out  1  start-of-frame pulse (optional feature)

Behaviour:
- Clock and reset:
  - Single clock domain; reset is synchronous and active-high.
  - On reset: h_cnt=0, v_cnt=0, pix_req_o=0, pix_x_o=0, pix_y_o=0, de_o=0, rgb_o=0.
  - hsync_o and vsync_o reset to the inactive level (~SYNC_POL).
  - Every delay-pipeline stage is cleared to inactive.
- Counters:
  - H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters. Both are localparams.
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments only when h_cnt == H_TOTAL-1, and wraps from V_TOTAL-1 to 0.
  - Segment order within a line and a frame: sync, back porch, active, front porch. Count 0 is the first sync clock/line.
  - Widths: 12-bit counters. Parameter sums above 4095 are illegal (elaboration-time check).
- Region decode, on the current counters:
  - hs_raw = (h_cnt < H_SYNC); vs_raw = (v_cnt < V_SYNC).
  - h_act = (h_cnt >= H_SYNC+H_BACK) && (h_cnt < H_SYNC+H_BACK+H_VALID).
  - v_act is the same form on v_cnt using the V_* parameters.
- Request stage, registered, one clock after the counters:
  - pix_req_o = h_act && v_act.
  - When pix_req_o=1: pix_x_o = h_cnt-(H_SYNC+H_BACK) and pix_y_o = v_cnt-(V_SYNC+V_BACK).
  - When pix_req_o=0: pix_x_o and pix_y_o are 0.
- Alignment pipeline:
  - hs_raw, vs_raw and the request flag are delayed by PIX_LAT+1 registers after the request stage.
  - hsync_o = delayed hs XOR ~SYNC_POL (i.e. active at SYNC_POL). vsync_o is formed the same way.
  - de_o = delayed request flag.
  - rgb_o is registered from pix_data_i when the stage-PIX_LAT request flag is 1, otherwise 0.
  - rgb_o is never nonzero while de_o=0.
- Latency:
  - Fixed PIX_LAT+2 clocks from the counters to all outputs; all outputs are mutually aligned.
  - With PIX_LAT=1: pix_x_o=0 at clock t, and the pixel for x=0 appears on rgb_o with de_o=1 at t+2.
- Line and frame properties: exactly H_VALID de_o clocks per active line, V_VALID active lines per frame, with no gaps inside a line.
- Mid-frame reset: counters restart at 0/0 and the pipeline flushes. The first post-reset output is a sync clock; no partial de burst is emitted after reset release.
- No backpressure: pix_data_i is sampled unconditionally. The source must honour PIX_LAT.

Optional Feature:
- Macro: VGA_TIMING_STATUS_EN.
- Defined:
  - sof_o pulses for 1 clock, aligned with the output stage, when (h_cnt,v_cnt) == (0,0).
  - frame_cnt_o increments by 1 on each sof_o and wraps from 0xFFFF to 0.
  - Both reset to 0.
- Undefined: sof_o and frame_cnt_o are tied to 0 and no counter logic is synthesised.

Decomposition:
- Shared package vga_pkg holds:
  - RGB565 colour constants
  - the 1080p60 and 720p60 timing constant sets
  - a timing-set struct typedef (sync, back, valid, front for H and V)
- Natural sub-module: vga_delay_line. A parameterised DEPTH x WIDTH shift register with synchronous reset value, used for the sync/de alignment.

Test Plan:
- Reset check: hold rst_i for 5 clocks, SYNC_POL=1 -> hsync_o=0, vsync_o=0, de_o=0, rgb_o=0, pix_req_o=0 throughout.
- Reduced timing (H 4/4/8/4, V 2/2/4/2, PIX_LAT=1) -> hsync_o high 4 clocks per 20-clock line, vsync_o high 40 clocks per 200-clock frame, 8 de_o clocks per active line, 4 active lines.
- Coordinate loopback: source returns {pix_y[3:0],pix_x[11:0]} with 1-clock latency -> every de_o clock shows rgb_o equal to the expected coordinate; first = 0x0000, last = 0x3007.
- PIX_LAT=3 with the same loopback -> identical rgb_o/de_o/hsync_o relationship, shifted 2 clocks later versus PIX_LAT=1.
- Reset asserted at h_cnt=10, v_cnt=3, then released -> next output is a sync clock and the full line/frame counts are correct.
- Default 1080p60 over 2 frames with VGA_TIMING_STATUS_EN -> 2,475,000 clocks per frame, 2,073,600 de_o clocks, sof_o once per frame, frame_cnt_o 0->1->2.
